// File: rtl/enemy_pkg.sv
// enemy_pkg: shared constants, colours and enums for the enemy actor.
package enemy_pkg;
    localparam logic [3:0]  ENEMY_STATE = 4'b1000;
    localparam int          SCREEN_W    = 1024;
    localparam int          SCREEN_H    = 768;
    localparam int          SPRITE_SIZE = 32;
    localparam int          EYE_SIZE    = 8;
    localparam int          X_MAX       = SCREEN_W - SPRITE_SIZE;
    localparam int          Y_MAX       = SCREEN_H - SPRITE_SIZE;
    localparam int          EYE_MID     = (SPRITE_SIZE - EYE_SIZE) / 2;
    localparam int          EYE_FAR     = SPRITE_SIZE - EYE_SIZE;
    localparam logic [11:0] COLOR_EYE   = 12'hFF0;
    localparam logic [11:0] COLOR_FLASH = 12'hFFF;
    localparam logic [11:0] COLOR_NONE  = 12'h000;

    typedef enum logic [1:0] {RIGHT, DOWN, LEFT, UP} dir_t;
    typedef enum logic [1:0] {IDLE, ACT, DONE} fsm_t;

    function automatic int clamp(input int v, input int hi);
        return v < 0 ? 0 : (v > hi ? hi : v);
    endfunction
endpackage

// File: rtl/enemy_sprite.sv
// enemy_sprite: combinational 32x32 hit test and colour select for one raster pixel.
// Define ENEMY_FLASH_EN to render the body white while an action is busy.
module enemy_sprite
    import enemy_pkg::*;
(
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  dir_t        dir_in,
    input  logic [3:0]  turn_in,
    input  logic        busy_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [11:0] pixel_out
);
`ifdef ENEMY_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic [10:0] dh;
    logic [9:0]  dv;
    logic        in_h, in_v, mid_h, mid_v, eye;
    logic [11:0] body;

    always_comb begin
        dh        = hcount_in - x_in;
        dv        = vcount_in - y_in;
        in_h      = hcount_in >= x_in && dh < 11'(SPRITE_SIZE);
        in_v      = vcount_in >= y_in && dv < 10'(SPRITE_SIZE);
        mid_h     = dh >= 11'(EYE_MID) && dh < 11'(EYE_MID + EYE_SIZE);
        mid_v     = dv >= 10'(EYE_MID) && dv < 10'(EYE_MID + EYE_SIZE);
        // Eye sits on the edge the sprite is facing, centred along that edge.
        eye       = in_h && in_v && (dir_in == RIGHT ? dh >= 11'(EYE_FAR) && mid_v :
                                     dir_in == LEFT  ? dh <  11'(EYE_SIZE) && mid_v :
                                     dir_in == DOWN  ? dv >= 10'(EYE_FAR) && mid_h :
                                                       dv <  10'(EYE_SIZE) && mid_h);
        body      = (FLASH && busy_in) ? COLOR_FLASH : {4'hF, turn_in, 4'h0};
        pixel_out = eye ? COLOR_EYE : (in_h && in_v) ? body : COLOR_NONE;
    end
endmodule

// File: rtl/enemy.sv
// enemy: enemy actor -- one timed, moving action per game enemy phase plus registered sprite pixel.
// Optional attack flash enabled by defining ENEMY_FLASH_EN.
module enemy
    import enemy_pkg::*;
#(
    parameter int ACTION_CYCLES = 16,
    parameter int STEP          = 32,
    parameter int X0            = 512,
    parameter int Y0            = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [3:0]  state_in,
    input  logic [3:0]  turn_in,
    input  logic [1:0]  rotate_in,
    output logic        busy_out,
    output logic        finished_out,
    output logic [11:0] pixel_out
);
    localparam int CW = ACTION_CYCLES > 1 ? $clog2(ACTION_CYCLES) : 1;

    fsm_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [3:0]  turn_q, turn_d;
    dir_t        rot_q, rot_d;
    logic        busy_q, busy_d, fin_q, fin_d;
    logic [11:0] pix_q, pix_d;
    logic        trigger, last;

    always_comb begin
        trigger = state_q == IDLE && armed_q && state_in == ENEMY_STATE;
        last    = state_q == ACT && cnt_q == CW'(ACTION_CYCLES - 1);
        state_d = state_q;
        cnt_d   = state_q == ACT ? cnt_q + 1'b1 : cnt_q;
        armed_d = state_q == IDLE ? (armed_q || state_in != ENEMY_STATE) : armed_q;
        turn_d  = trigger ? turn_in : turn_q;
        rot_d   = trigger ? dir_t'(rotate_in) : rot_q;
        x_d     = x_q;
        y_d     = y_q;
        if (trigger) begin
            state_d = ACT;
            cnt_d   = '0;
            armed_d = 1'b0;
        end
        if (last) begin
            state_d = DONE;
            x_d = rot_q == RIGHT ? 11'(clamp(int'(x_q) + STEP, X_MAX)) :
                  rot_q == LEFT  ? 11'(clamp(int'(x_q) - STEP, X_MAX)) : x_q;
            y_d = rot_q == DOWN  ? 10'(clamp(int'(y_q) + STEP, Y_MAX)) :
                  rot_q == UP    ? 10'(clamp(int'(y_q) - STEP, Y_MAX)) : y_q;
        end
        if (state_q == DONE) state_d = IDLE;
        busy_d = state_d == ACT;
        fin_d  = state_d == DONE;
    end

    enemy_sprite u_sprite (
        .x_in      (x_q),
        .y_in      (y_q),
        .dir_in    (rot_q),
        .turn_in   (turn_q),
        .busy_in   (busy_q),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .pixel_out (pix_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            x_q     <= 11'(X0);
            y_q     <= 10'(Y0);
            turn_q  <= '0;
            rot_q   <= RIGHT;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            pix_q   <= COLOR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            x_q     <= x_d;
            y_q     <= y_d;
            turn_q  <= turn_d;
            rot_q   <= rot_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            pix_q   <= pix_d;
        end
    end

    assign busy_out     = busy_q;
    assign finished_out = fin_q;
    assign pixel_out    = pix_q;
endmodule

// File: tb/tb_enemy.sv
// tb_enemy: directed scoreboard bench for the enemy actor.
module tb_enemy;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic [3:0]  state_in = '0;
    logic [3:0]  turn_in = '0;
    logic [1:0]  rotate_in = '0;
    logic        busy_out, finished_out;
    logic [11:0] pixel_out;

    int checks = 0;
    int errors = 0;

`ifdef ENEMY_FLASH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [11:0] pix;
        logic        busy;
        logic        fin;
    } exp_t;

    exp_t sb[$];

    enemy dut (
        .clk          (clk),
        .rst          (rst),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .state_in     (state_in),
        .turn_in      (turn_in),
        .rotate_in    (rotate_in),
        .busy_out     (busy_out),
        .finished_out (finished_out),
        .pixel_out    (pixel_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] body(input logic [3:0] t, input logic b);
        return (FL && b) ? 12'hFFF : {4'hF, t, 4'h0};
    endfunction

    task automatic step(input logic [3:0] st, input logic [10:0] h, input logic [9:0] v,
                        input logic [11:0] ep, input logic eb, input logic ef, input string tag);
        exp_t e;
        state_in  = st;
        hcount_in = h;
        vcount_in = v;
        sb.push_back('{tag, ep, eb, ef});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pix"}, pixel_out, e.pix);
        chk({e.tag, ".busy"}, 12'(busy_out), 12'(e.busy));
        chk({e.tag, ".fin"}, 12'(finished_out), 12'(e.fin));
    endtask

    initial begin
        int xm, nx;
        logic [3:0] prev;
        logic [11:0] ep;
        hcount_in = 11'd513;
        vcount_in = 10'd256;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.pix", pixel_out, 12'h000);
        chk("rst.busy", 12'(busy_out), 12'h0);
        chk("rst.fin", 12'(finished_out), 12'h0);
        rst = 1'b1;
        step(4'h0, 11'd513, 10'd256, 12'hF00, 1'b0, 1'b0, "idle_body");

        // Held trigger: one action only; j==5 probes the right-facing eye.
        for (int j = 0; j < 100; j++) begin
            ep = j == 5 ? 12'hFF0 : j <= 16 ? body(4'h0, j >= 1) : 12'h000;
            step(4'h8, j == 5 ? 11'd540 : 11'd513, j == 5 ? 10'd270 : 10'd256,
                 ep, j <= 15, j == 16, "hold");
        end

        // Left moves from x=544 down to 0 and five beyond, checking saturation.
        xm = 544;
        prev = 4'h0;
        turn_in = 4'h5;
        rotate_in = 2'd2;
        for (int a = 0; a < 22; a++) begin
            step(4'h0, 11'(xm + 1), 10'd257, body(prev, 1'b0), 1'b0, 1'b0, "rearm");
            nx = xm < 32 ? 0 : xm - 32;
            for (int j = 0; j < 18; j++) begin
                ep = j == 17 ? (nx == xm ? body(4'h5, 1'b0) : 12'h000)
                             : body(j == 0 ? prev : 4'h5, j >= 1);
                step(4'h8, 11'(xm + 1), 10'd257, ep, j <= 15, j == 16, "left");
            end
            prev = 4'h5;
            xm = nx;
        end
        step(4'h0, 11'd0, 10'd256, 12'hF50, 1'b0, 1'b0, "sat0");

        // Trigger dropped mid-action: action still completes, moving down.
        turn_in = 4'h0;
        rotate_in = 2'd1;
        for (int j = 0; j < 18; j++) begin
            ep = j == 17 ? 12'h000 : body(j == 0 ? 4'h5 : 4'h0, j >= 1);
            step(j < 4 ? 4'h8 : 4'h0, 11'd1, 10'd260, ep, j <= 15, j == 16, "drop");
        end
        step(4'h0, 11'd1, 10'd300, 12'hF00, 1'b0, 1'b0, "rearm2");

        // Reset in the middle of an action.
        for (int j = 0; j < 5; j++)
            step(4'h8, 11'd1, 10'd300, body(4'h0, j >= 1), 1'b1, 1'b0, "pre_rst");
        rst = 1'b0;
        #1;
        chk("mid_rst.pix", pixel_out, 12'h000);
        chk("mid_rst.busy", 12'(busy_out), 12'h0);
        chk("mid_rst.fin", 12'(finished_out), 12'h0);
        for (int j = 0; j < 20; j++)
            step(4'h8, 11'd1, 10'd300, 12'h000, 1'b0, 1'b0, "in_rst");
        rst = 1'b1;
        step(4'h0, 11'd513, 10'd256, 12'hF00, 1'b0, 1'b0, "post_rst");
        step(4'h0, 11'd540, 10'd270, 12'hFF0, 1'b0, 1'b0, "post_rst_eye");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/enemy.md
# enemy

The `enemy` block is the enemy actor for the game's video pipeline. It sits between the top-level game FSM and the pixel mixer. When the game FSM enters the enemy phase, the block runs one timed action and moves its position one step in the commanded direction. It reports the action with a busy/finished handshake. On every cycle it also renders a 32×32 enemy sprite for the pixel at the current raster position.

## Interface
Parameters:
- `ACTION_CYCLES`, default 16: length of one enemy action in clock cycles; must be ≥1.
- `STEP`, default 32: pixels moved per completed action.
- `X0`, default 512: reset x position of the sprite's top-left corner.
- `Y0`, default 256: reset y position of the sprite's top-left corner.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset; asynchronous, active-low (port keeps the codebase name `rst`; polarity and synchronicity are fixed).
- `hcount_in`  in  11: raster x coordinate, active range 0..1023.
- `vcount_in`  in  10: raster y coordinate, active range 0..767.
- `state_in`  in  4: game FSM state; `ENEMY_STATE` = 4'b1000 starts an action.
- `turn_in`  in  4: turn number; latched at action start; tints the body colour.
- `rotate_in`  in  2: facing/move direction, latched at action start. 0 = right, 1 = down, 2 = left, 3 = up.
- `busy_out`  out  1: high while an action is in progress.
- `finished_out`  out  1: one-cycle pulse when an action completes.
- `pixel_out`  out  12: RGB444 pixel; 12'h000 means transparent.

## Operation
- FSM has three states, all transitions on the rising edge of `clk`:
  - IDLE → ACT when `armed` and `state_in`==`ENEMY_STATE`. In the same edge: latch `turn_in` and `rotate_in`, clear the cycle counter, clear `armed`.
  - ACT: counter increments each cycle. When counter==`ACTION_CYCLES`-1, go to DONE and update the position.
  - DONE → IDLE unconditionally.
- `armed` rule: set in IDLE whenever `state_in`≠`ENEMY_STATE`. It is 1 after reset. Holding `state_in` at `ENEMY_STATE` therefore produces exactly one action.
- If `state_in` leaves `ENEMY_STATE` mid-action, the action still completes normally.
- Position update by latched direction:
  - right: x+STEP; down: y+STEP; left: x−STEP; up: y−STEP.
  - Saturate x to 0..992 and y to 0..736; never wrap.
- Sprite region: `hcount_in` in [x, x+31] and `vcount_in` in [y, y+31].
- Eye: an 8×8 square on the facing edge.
  - right: h x+24..x+31, v y+12..y+19.
  - left: h x..x+7, v y+12..y+19.
  - down: h x+12..x+19, v y+24..y+31.
  - up: h x+12..x+19, v y..y+7.
- Pixel priority:
  - eye → 12'hFF0;
  - else body → {4'hF, turn_latched, 4'h0};
  - else outside the sprite → 12'h000.
  - Position and latched values are read from registers and take effect on the cycle after they update.

## Timing
- Reset values: `busy_out`=0, `finished_out`=0, `pixel_out`=12'h000, FSM=IDLE, armed=1, x=X0, y=Y0, turn_latched=0, rotate_latched=0.
- Trigger sampled at edge t: `busy_out` is high for cycles t+1 .. t+`ACTION_CYCLES`.
- `finished_out` is high for exactly cycle t+`ACTION_CYCLES`+1. The new position is visible from that cycle.
- `busy_out` and `finished_out` are registered and never high together.
- `pixel_out` is registered with 1-cycle latency from `hcount_in`/`vcount_in`.
- Reset asserted mid-action aborts immediately to reset values; no `finished_out` pulse.

## Configuration
- `ENEMY_FLASH_EN` defined: while `busy_out`=1, the body (not the eye) renders 12'hFFF as an attack flash.
- `ENEMY_FLASH_EN` undefined: the body colour is always {4'hF, turn_latched, 4'h0}.

## Structure
- Package `enemy_pkg` holds:
  - `ENEMY_STATE`;
  - screen limits (1024×768, sprite size 32, eye size 8);
  - colour constants: eye 12'hFF0, flash 12'hFFF, transparent 12'h000;
  - direction enum `dir_t` (RIGHT, DOWN, LEFT, UP);
  - FSM enum (IDLE, ACT, DONE).
- Sub-module `enemy_sprite` is the combinational hit test and colour select. Its inputs are x, y, direction, turn, busy, hcount and vcount. The top registers its output.

## Test plan
- Reset, `rotate_in`=0, `turn_in`=0, `state_in`=0, h=513, v=256: `pixel_out`=12'hF00 one cycle later; `busy_out`=0, `finished_out`=0.
- Hold `state_in`=4'b1000 for 100 cycles (`turn_in`=0, `rotate_in`=0): busy for 16 cycles, then one `finished_out` pulse, then no second action. x becomes 544, so h=513, v=256 gives 12'h000.
- With `ENEMY_FLASH_EN`: during busy, h=513, v=256 gives 12'hFFF. h=540, v=270 (eye, facing right) gives 12'hFF0.
- `rotate_in`=2 with x at 0: five left actions, each re-armed by dropping `state_in` to 0 for one cycle. x saturates at 0, no wrap; `turn_in`=5 → body 12'hF50.
- Drop `state_in` mid-action: the action still finishes with `finished_out` at cycle t+17. Assert `rst` low mid-action: outputs return to reset values with no `finished_out` pulse.
